// File: rtl/seq_divider_if.sv
// seq_divider_if: start/valid handshake and operand/result bus of the sequential divider
//   dividend[7:0], divisor[3:0], start : requester -> divider
//   quotient[7:0], remainder[3:0], valid, busy, div_by_zero : divider -> requester
interface seq_divider_if;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       start;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       valid;
  logic       busy;
  logic       div_by_zero;
  modport master (output dividend, divisor, start, input quotient, remainder, valid, busy, div_by_zero);
  modport slave (input dividend, divisor, start, output quotient, remainder, valid, busy, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: 8/4-bit unsigned restoring divider, one quotient bit per clock
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : seq_divider_if.slave (operands, start, results, valid, busy, div_by_zero)
//   SEQ_DIVIDER_DBZ_DETECT_EN : when defined, divisor 0 finishes after one cycle with div_by_zero set
module seq_divider (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0] r_state;
  logic [7:0] r_d;
  logic [3:0] r_r, r_dv;
  logic [2:0] r_cnt;
  logic       r_dbz;
  logic [4:0] w_r_sh;
  logic [3:0] w_r_nx;
  logic       w_ge, w_accept, w_zero;
  // r_d shifts dividend bits out the top and quotient bits in at the bottom
  always_comb begin
    w_r_sh = {r_r, r_d[7]};
    w_ge = w_r_sh >= {1'b0, r_dv};
    // the restored/subtracted remainder is always below the divisor, so 4 bits hold it
    w_r_nx = w_ge ? 4'(w_r_sh - {1'b0, r_dv}) : w_r_sh[3:0];
    w_accept = bus.start && r_state != CALC;
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
    w_zero = r_dv == 4'd0;
`else
    w_zero = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_d <= '0;
      r_r <= '0;
      r_dv <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_state <= CALC;
      r_d <= bus.dividend;
      r_dv <= bus.divisor;
      r_r <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else if (r_state == CALC) begin
      if (w_zero) begin
        r_state <= DONE;
        r_d <= 8'hFF;
        r_r <= '0;
        r_dbz <= 1'b1;
      end else begin
        r_d <= {r_d[6:0], w_ge};
        r_r <= w_r_nx;
        r_cnt <= r_cnt + 3'd1;
        r_state <= r_cnt == 3'd7 ? DONE : CALC;
      end
    end
  assign bus.quotient = r_d;
  assign bus.remainder = r_r;
  assign bus.valid = r_state == DONE;
  assign bus.busy = r_state == CALC;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider against an arithmetic reference model
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset = 1'b0;
  seq_divider_if bus ();
  seq_divider dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 8'hFF;
      e.r = DBZ ? 4'h0 : 4'(a % 16);
      e.z = DBZ;
    end else begin
      e.q = 8'(a / b);
      e.r = 4'(a % b);
      e.z = 1'b0;
    end
    return e;
  endfunction
  function automatic int lat(input int b);
    return (b == 0 && DBZ) ? 1 : 8;
  endfunction
  logic pv = 1'b0;
  always @(negedge clk) begin
    if (bus.valid && !pv) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got q=%0d r=%0d expected none", bus.quotient, bus.remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", bus.quotient, e.q);
        chk("remainder", bus.remainder, e.r);
        chk("div_by_zero", bus.div_by_zero, e.z);
      end
    end
    pv = bus.valid;
  end
  task automatic accept(input int a, input int b);
    @(negedge clk);
    bus.dividend = 8'(a);
    bus.divisor = 4'(b);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("accept_busy", bus.busy, 1);
    chk("accept_valid", bus.valid, 0);
  endtask
  task automatic finish_op(input int l, input int elapsed, input bit scramble);
    int n = elapsed;
    int bz = elapsed + 1;
    while (!bus.valid && n < 20) begin
      if (scramble) begin
        bus.dividend = 8'($urandom);
        bus.divisor = 4'($urandom);
      end
      @(posedge clk);
      #1 n++;
      if (bus.busy) bz++;
    end
    chk("latency", n, l);
    chk("busy_cycles", bz, l);
    chk("done_busy", bus.busy, 0);
  endtask
  task automatic run(input int a, input int b, input bit scramble);
    sb.push_back(model(a, b));
    accept(a, b);
    finish_op(lat(b), 0, scramble);
  endtask
  initial begin
    int a, b, vc;
    bit prev;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.start = 1'b0;
    #12;
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    @(negedge clk) reset = 1'b1;
    run(200, 7, 0);
    run(255, 15, 0);
    run(5, 9, 0);
    run(0, 1, 0);
    run(13, 0, 0);
    run(200, 7, 1);
    // start pulse while busy must not disturb 100/3
    sb.push_back(model(100, 3));
    accept(100, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.dividend = 8'd50;
    bus.divisor = 4'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    finish_op(8, 3, 0);
    // asynchronous reset mid-operation
    accept(200, 7);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_valid", bus.valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_dbz", bus.div_by_zero, 0);
    @(negedge clk) reset = 1'b1;
    run(9, 2, 0);
    // continuous start: one result every 9 cycles, valid high one cycle
    repeat (3) sb.push_back(model(60, 4));
    @(negedge clk);
    bus.dividend = 8'd60;
    bus.divisor = 4'd4;
    bus.start = 1'b1;
    vc = 0;
    prev = 1'b0;
    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid) vc++;
      if (bus.valid && prev) chk("valid_one_cycle", 2, 1);
      prev = bus.valid;
    end
    bus.start = 1'b0;
    chk("b2b_results", vc, 3);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      run(a, b, 1);
    end
    repeat (5) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned divisor, producing an 8-bit quotient and a 4-bit remainder, one quotient bit per clock. It is the inverse-direction companion to the sequential multiplier and uses the same start/valid handshake, so it can feed the same four-digit seven-segment display path. Results are held stable until the next accepted start.

## Interface
Parameters: none; widths are fixed.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- dividend  in  8  unsigned dividend; sampled only on the start-accept edge
- divisor  in  4  unsigned divisor; sampled only on the start-accept edge
- start  in  1  request; level-sampled, accepted only in IDLE or DONE
- quotient  out  8  result quotient; valid while valid=1
- remainder  out  4  result remainder; valid while valid=1
- valid  out  1  result ready; held high until the next accepted start
- busy  out  1  high while iterating
- div_by_zero  out  1  divide-by-zero flag; see Configuration

## Operation
- States: IDLE, CALC, DONE.
- IDLE or DONE with start=1:
  - latch dividend into the shift register and divisor into the divisor register;
  - clear the 5-bit partial remainder R and the iteration counter;
  - clear valid and div_by_zero; set busy; go to CALC.
- CALC, each cycle:
  - R = {R[3:0], D[7]}, then D shifts left by 1;
  - if R >= {1'b0, divisor}: R = R - divisor, new quotient LSB = 1; else quotient LSB = 0;
  - counter increments; after the 8th iteration go to DONE.
- DONE: quotient = D register, remainder = R[3:0], valid=1, busy=0. Stay in DONE until start.
- start while busy=1 is ignored, with no effect on the operation in progress.
- R never exceeds 5 bits, and R[3:0] holds the final remainder, always < divisor for divisor ≠ 0.
- Operand changes outside the accept edge have no effect.

## Timing
- Reset values: quotient=0, remainder=0, valid=0, busy=0, div_by_zero=0, state IDLE.
- Reset mid-operation aborts immediately. The first start after reset deasserts is accepted normally.
- Start accepted at edge N:
  - busy=1 and valid=0 after edge N;
  - iterations occur on edges N+1 through N+8;
  - valid=1 and busy=0 after edge N+8.
- Latency is 8 cycles from the accept edge to valid.
- Back-to-back operation: start held high in DONE is accepted on the next edge, and valid drops after that edge. A continuously high start gives one result every 9 cycles with valid high for one cycle.

## Configuration
- Macro: SEQ_DIVIDER_DBZ_DETECT_EN.
- Defined:
  - divisor=0 at the accept edge goes directly to DONE on edge N+1;
  - outputs quotient=8'hFF, remainder=4'h0, div_by_zero=1, valid=1;
  - div_by_zero clears on the next accepted start.
- Undefined:
  - div_by_zero is tied to 0;
  - divisor=0 runs the normal 8 iterations and yields quotient=8'hFF, remainder=dividend[3:0];
  - valid rises at edge N+8.

## Test plan
- 200/7: start at edge N → valid after edge N+8, quotient=28, remainder=4; busy high for exactly 8 cycles.
- 255/15 → quotient=17, remainder=0. 5/9 → quotient=0, remainder=5. 0/1 → quotient=0, remainder=0.
- 13/0, macro defined → after N+1: valid=1, div_by_zero=1, quotient=8'hFF, remainder=0. Macro undefined → after N+8: quotient=8'hFF, remainder=4'hD, div_by_zero=0.
- Start 100/3, then pulse start with 50/5 at N+3 → ignored; result after N+8 is quotient=33, remainder=1.
- Start 200/7, then reset=0 at N+4 → all outputs 0 immediately. After release, start 9/2 → quotient=4, remainder=1 after 8 cycles.
- Start held high continuously with 60/4 → valid pulses one cycle every 9 cycles, quotient=15, remainder=0 each time.
